// File: rtl/adc_capture_ctrl.sv
// Trigger/decimation controller that captures one frame of ADC samples into a buffer.
// The config is latched at arm time, so the inputs may change while a capture is running.
module adc_capture_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        trig_mode,
  input  logic              ext_trig,
  input  logic [DATA_W-1:0] trig_level,
  input  logic [7:0]        decim,
  input  logic [ADDR_W-1:0] frame_len_m1,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_in,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              armed,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

  typedef struct packed {
    logic [1:0]        mode;
    logic [DATA_W-1:0] level;
    logic [7:0]        decim;
    logic [ADDR_W-1:0] flen_m1;
  } cfg_t;

  state_t             state_q, state_d;
  cfg_t               cfg_q;
  logic [DATA_W-1:0]  prev_q;
  logic               fresh_q;
  logic [7:0]         dcnt_q;
  logic [ADDR_W-1:0]  addr_q;
  logic               arm_now, write_now, trig_hit, last_wr;

  // Crossing modes need a valid previous sample from this arming.
  always_comb begin
    trig_hit = 1'b0;
    case (cfg_q.mode)
      2'b00: trig_hit = 1'b1;
      2'b01: trig_hit = !fresh_q && ($signed(prev_q) <  $signed(cfg_q.level))
                                 && ($signed(sample_in) >= $signed(cfg_q.level));
      2'b10: trig_hit = !fresh_q && ($signed(prev_q) >= $signed(cfg_q.level))
                                 && ($signed(sample_in) <  $signed(cfg_q.level));
      default: trig_hit = ext_trig;
    endcase
  end

  assign last_wr = (addr_q == cfg_q.flen_m1);

  always_comb begin
    state_d   = state_q;
    arm_now   = 1'b0;
    write_now = 1'b0;
    case (state_q)
      IDLE: if (start && !abort) begin
        state_d = ARMED;
        arm_now = 1'b1;
      end
      ARMED: begin
        if (abort) state_d = IDLE;
        else if (sample_valid && trig_hit) begin
          write_now = 1'b1;
          state_d   = last_wr ? DONE : CAPTURE;
        end
      end
      CAPTURE: begin
        if (abort) state_d = IDLE;
        else if (sample_valid && dcnt_q == 8'd0) begin
          write_now = 1'b1;
          if (last_wr) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cfg_q   <= '0;
      prev_q  <= '0;
      fresh_q <= 1'b0;
      dcnt_q  <= '0;
      addr_q  <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      state_q <= state_d;
      wr_en   <= write_now;
      if (sample_valid) prev_q <= sample_in;
      if (arm_now) begin
        cfg_q   <= '{mode: trig_mode, level: trig_level, decim: decim, flen_m1: frame_len_m1};
        fresh_q <= 1'b1;
        dcnt_q  <= '0;
        addr_q  <= '0;
      end else if (state_q == ARMED && sample_valid) begin
        fresh_q <= 1'b0;
      end
      // Each write reloads the skip count; skipped valids count it down to 0.
      if (write_now) begin
        addr_q  <= addr_q + ADDR_W'(1);
        dcnt_q  <= cfg_q.decim;
        wr_addr <= addr_q;
        wr_data <= sample_in;
      end else if (state_q == CAPTURE && sample_valid && !abort && dcnt_q != 8'd0) begin
        dcnt_q  <= dcnt_q - 8'd1;
      end
    end
  end

  assign busy  = (state_q == ARMED) || (state_q == CAPTURE);
  assign armed = (state_q == ARMED);
  assign done  = (state_q == DONE);

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed bench for adc_capture_ctrl: trigger modes, decimation, abort, reset, frame length.
module tb_adc_capture_ctrl;
  localparam int DW = 8;
  localparam int AW = 10;

  logic          clk = 1'b0, rst = 1'b1;
  logic          start = 1'b0, abort = 1'b0, ext_trig = 1'b0, sample_valid = 1'b0;
  logic [1:0]    trig_mode = '0;
  logic [DW-1:0] trig_level = '0, sample_in = '0;
  logic [7:0]    decim = '0;
  logic [AW-1:0] frame_len_m1 = '0;
  logic          wr_en, busy, armed, done;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  int total = 0, bad = 0;

  adc_capture_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .trig_mode(trig_mode),
    .ext_trig(ext_trig), .trig_level(trig_level), .decim(decim),
    .frame_len_m1(frame_len_m1), .sample_valid(sample_valid), .sample_in(sample_in),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .armed(armed), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // Arm with cfg, then scramble the inputs so that only the latched copy can be right.
  task automatic arm(input logic [1:0] m, input int lvl, input int dc, input int fl);
    trig_mode = m; trig_level = lvl[DW-1:0]; decim = dc[7:0]; frame_len_m1 = fl[AW-1:0];
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    trig_mode = ~m; trig_level = ~lvl[DW-1:0]; decim = ~dc[7:0]; frame_len_m1 = ~fl[AW-1:0];
    chk("arm.armed", 32'(armed), 32'd1);
    chk("arm.busy", 32'(busy), 32'd1);
  endtask

  // One clock with optional sample; checks registered write and done afterwards.
  task automatic smp(input string tag, input bit v, input int d,
                     input bit ewe, input int ea, input bit edone);
    sample_valid = v; sample_in = d[DW-1:0];
    @(posedge clk); #1;
    sample_valid = 1'b0;
    chk({tag, ".we"}, 32'(wr_en), 32'(ewe));
    if (ewe) begin
      chk({tag, ".addr"}, 32'(wr_addr), 32'(ea));
      chk({tag, ".data"}, 32'(wr_data), 32'(d[DW-1:0]));
    end
    chk({tag, ".done"}, 32'(done), 32'(edone));
  endtask

  task automatic all_zero(input string tag);
    chk({tag, ".we"}, 32'(wr_en), 0);
    chk({tag, ".addr"}, 32'(wr_addr), 0);
    chk({tag, ".data"}, 32'(wr_data), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".armed"}, 32'(armed), 0);
    chk({tag, ".done"}, 32'(done), 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    all_zero("rst");
    rst = 1'b0;

    // immediate trigger, every sample, 4-sample frame
    arm(2'b00, 0, 0, 3);
    smp("m0.s0", 1, 5,  1, 0, 0);
    smp("m0.s1", 1, -2, 1, 1, 0);
    smp("m0.s2", 1, 7,  1, 2, 0);
    smp("m0.s3", 1, 1,  1, 3, 1);
    smp("m0.end", 0, 0, 0, 0, 0);
    chk("m0.busy", 32'(busy), 0);

    // rising crossing; prev=-5 before arming must not make 3 a trigger
    smp("m1.pre", 1, -5, 0, 0, 0);
    arm(2'b01, 0, 0, 3);
    smp("m1.fresh", 1, 3,  0, 0, 0);
    smp("m1.a", 1, -3, 0, 0, 0);
    smp("m1.b", 1, -1, 0, 0, 0);
    smp("m1.trg", 1, 2, 1, 0, 0);
    chk("m1.cap.armed", 32'(armed), 0);
    chk("m1.cap.busy", 32'(busy), 1);
    smp("m1.s1", 1, 4, 1, 1, 0);
    smp("m1.gap", 0, 0, 0, 0, 0);
    smp("m1.s2", 1, 6, 1, 2, 0);
    smp("m1.s3", 1, 8, 1, 3, 1);
    smp("m1.end", 0, 0, 0, 0, 0);

    // falling crossing with decimation by 3
    arm(2'b10, 10, 2, 1);
    smp("m2.a", 1, 20, 0, 0, 0);
    smp("m2.b", 1, 12, 0, 0, 0);
    smp("m2.trg", 1, 9, 1, 0, 0);
    smp("m2.k1", 1, 8, 0, 0, 0);
    smp("m2.gap", 0, 0, 0, 0, 0);
    smp("m2.k2", 1, 7, 0, 0, 0);
    smp("m2.s1", 1, 6, 1, 1, 1);
    smp("m2.end", 1, 5, 0, 0, 0);

    // external trigger, single-sample frame
    arm(2'b11, 0, 0, 0);
    smp("m3.no", 1, 50, 0, 0, 0);
    ext_trig = 1'b1;
    smp("m3.trg", 1, 51, 1, 0, 1);
    ext_trig = 1'b0;
    smp("m3.end", 0, 0, 0, 0, 0);

    // abort mid-capture, then restart from address 0
    arm(2'b00, 0, 0, 7);
    smp("ab.s0", 1, 11, 1, 0, 0);
    smp("ab.s1", 1, 12, 1, 1, 0);
    abort = 1'b1;
    smp("ab.cut", 1, 13, 0, 0, 0);
    abort = 1'b0;
    chk("ab.busy", 32'(busy), 0);
    smp("ab.after", 1, 14, 0, 0, 0);
    arm(2'b00, 0, 0, 1);
    smp("ab.r0", 1, 21, 1, 0, 0);
    smp("ab.r1", 1, 22, 1, 1, 1);
    smp("ab.end", 0, 0, 0, 0, 0);

    // start and abort together in IDLE
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("sa.armed", 32'(armed), 0);
    chk("sa.busy", 32'(busy), 0);

    // asynchronous reset mid-capture with a valid sample pending
    arm(2'b00, 0, 0, 7);
    smp("rs.s0", 1, 31, 1, 0, 0);
    smp("rs.s1", 1, 32, 1, 1, 0);
    sample_valid = 1'b1; sample_in = 8'd33;
    #3 rst = 1'b1;
    #1 all_zero("rs.async");
    @(posedge clk); #1;
    rst = 1'b0;
    smp("rs.idle", 1, 34, 0, 0, 0);
    chk("rs.busy", 32'(busy), 0);
    arm(2'b00, 0, 0, 0);
    smp("rs.new", 1, 41, 1, 0, 1);
    smp("rs.end", 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
